usb_fifo_writer: RTL and testbench

//  Transmit side of the board's USB slave-FIFO link: buffers bytes from on-chip logic
//  and writes them to the USB controller over the shared usb_fd bus. Active-low write

---
 rtl/usb_fifo_writer.sv | 149 ++++++++++++++
 tb/tb_usb_fifo_writer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fifo_writer.sv
// Transmit side of the USB slave-FIFO link: buffers tagged bytes and writes them to the
// controller with an active-low strobe. Bus ownership is shared with the read path.
module usb_fifo_writer #(
    parameter int FIFO_DEPTH    = 16,
    parameter int STROBE_CYCLES = 2,
    parameter int AW            = 4
) (
    input  logic          usb_ifclk,
    input  logic          usb_reset,
    input  logic [7:0]    tx_data,
    input  logic          tx_cmd,
    input  logic          tx_valid,
    output logic          tx_ready,
    input  logic          usb_full,
    input  logic          usb_rd_busy,
    output logic [7:0]    usb_fd_out,
    output logic          usb_fd_oe,
    output logic          usb_wen,
    output logic          usb_cmd_data,
    output logic [AW:0]   fifo_level,
    output logic [31:0]   bytes_sent
);

    localparam int SCW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic       cmd;
        logic [7:0] data;
    } entry_t;

    typedef enum logic [2:0] {
        IDLE,
        TURN,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    entry_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_ptr_inc;
    logic [AW:0]     level;
    logic [AW:0]     level_nxt;
    state_t          state;
    logic [SCW-1:0]  strobe_cnt;
    logic            push;
    logic            pop;
    entry_t          tx_entry;
    entry_t          next_head;

    assign tx_ready   = (level != FULL_LVL);
    assign fifo_level = level;
    assign push       = tx_valid & tx_ready;
    assign pop        = (state == HOLD);
    assign tx_entry   = '{cmd: tx_cmd, data: tx_data};
    assign rd_ptr_inc = rd_ptr + AW'(1);

    // With a single entry left, the byte behind the head can only be the one arriving now.
    assign next_head  = (level > (AW+1)'(1)) ? mem[rd_ptr_inc] : tx_entry;

    always_comb begin
        level_nxt = level;
        if (push && !pop)
            level_nxt = level + (AW+1)'(1);
        else if (!push && pop)
            level_nxt = level - (AW+1)'(1);
    end

    always_ff @(posedge usb_ifclk) begin
        if (push)
            mem[wr_ptr] <= tx_entry;
    end

    always_ff @(posedge usb_ifclk) begin
        if (usb_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr_inc;
            level <= level_nxt;
        end
    end

    always_ff @(posedge usb_ifclk) begin
        if (usb_reset) begin
            state        <= IDLE;
            usb_fd_oe    <= 1'b0;
            usb_wen      <= 1'b1;
            usb_fd_out   <= 8'h00;
            usb_cmd_data <= 1'b0;
            strobe_cnt   <= '0;
            bytes_sent   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (level != '0 && !usb_rd_busy) begin
                        state        <= TURN;
                        usb_fd_oe    <= 1'b1;
                        usb_fd_out   <= mem[rd_ptr].data;
                        usb_cmd_data <= mem[rd_ptr].cmd;
                    end
                end
                TURN: state <= SETUP;
                SETUP: begin
                    if (usb_rd_busy) begin
                        state     <= IDLE;
                        usb_fd_oe <= 1'b0;
                    end else if (!usb_full) begin
                        state      <= STROBE;
                        usb_wen    <= 1'b0;
                        strobe_cnt <= SCW'(STROBE_CYCLES - 1);
                    end
                end
                // Once the strobe starts the write is committed; full/busy are ignored.
                STROBE: begin
                    if (strobe_cnt == '0) begin
                        state   <= HOLD;
                        usb_wen <= 1'b1;
                    end else begin
                        strobe_cnt <= strobe_cnt - SCW'(1);
                    end
                end
                HOLD: begin
                    bytes_sent <= bytes_sent + 32'd1;
                    if (level_nxt != '0 && !usb_rd_busy) begin
                        state        <= SETUP;
                        usb_fd_out   <= next_head.data;
                        usb_cmd_data <= next_head.cmd;
                    end else begin
                        state     <= IDLE;
                        usb_fd_oe <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    usb_fd_oe <= 1'b0;
                    usb_wen   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_fifo_writer.sv
// Directed bench for usb_fifo_writer: reset, single byte, burst, full stall,
// read-path preemption and mid-strobe reset.
module tb_usb_fifo_writer;

    logic        usb_ifclk = 1'b0;
    logic        usb_reset = 1'b1;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_cmd = 1'b0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        usb_full = 1'b0;
    logic        usb_rd_busy = 1'b0;
    logic [7:0]  usb_fd_out;
    logic        usb_fd_oe;
    logic        usb_wen;
    logic        usb_cmd_data;
    logic [4:0]  fifo_level;
    logic [31:0] bytes_sent;

    int vectors = 0;
    int errors  = 0;

    usb_fifo_writer #(.FIFO_DEPTH(16), .STROBE_CYCLES(2), .AW(4)) dut (
        .usb_ifclk(usb_ifclk), .usb_reset(usb_reset),
        .tx_data(tx_data), .tx_cmd(tx_cmd), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .usb_full(usb_full), .usb_rd_busy(usb_rd_busy),
        .usb_fd_out(usb_fd_out), .usb_fd_oe(usb_fd_oe), .usb_wen(usb_wen),
        .usb_cmd_data(usb_cmd_data), .fifo_level(fifo_level), .bytes_sent(bytes_sent)
    );

    always #5 usb_ifclk = ~usb_ifclk;

    task automatic step();
        @(posedge usb_ifclk);
        #1;
    endtask

    task automatic test_reset();
        usb_reset = 1'b1;
        repeat (3) step();
        usb_reset = 1'b0;
        repeat (10) step();
        vectors++; if (usb_fd_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", usb_fd_oe); end
        vectors++; if (usb_wen !== 1'b1) begin errors++; $display("FAIL reset_wen: got %b want 1", usb_wen); end
        vectors++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
        vectors++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        vectors++; if (bytes_sent !== 32'd0) begin errors++; $display("FAIL reset_sent: got %0d want 0", bytes_sent); end
        vectors++; if (usb_fd_out !== 8'h00) begin errors++; $display("FAIL reset_fd: got %h want 00", usb_fd_out); end
        vectors++; if (usb_cmd_data !== 1'b0) begin errors++; $display("FAIL reset_cmd: got %b want 0", usb_cmd_data); end
    endtask

    task automatic test_single();
        tx_data = 8'hA5; tx_cmd = 1'b1; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0; tx_cmd = 1'b0;
        vectors++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL single_level: got %0d want 1", fifo_level); end
        step();
        vectors++; if (usb_fd_oe !== 1'b1) begin errors++; $display("FAIL single_turn_oe: got %b want 1", usb_fd_oe); end
        vectors++; if (usb_fd_out !== 8'hA5) begin errors++; $display("FAIL single_fd: got %h want a5", usb_fd_out); end
        vectors++; if (usb_cmd_data !== 1'b1) begin errors++; $display("FAIL single_cmd: got %b want 1", usb_cmd_data); end
        vectors++; if (usb_wen !== 1'b1) begin errors++; $display("FAIL single_turn_wen: got %b want 1", usb_wen); end
        step();
        vectors++; if (usb_wen !== 1'b1) begin errors++; $display("FAIL single_setup_wen: got %b want 1", usb_wen); end
        step();
        vectors++; if (usb_wen !== 1'b0) begin errors++; $display("FAIL single_strobe1: got %b want 0", usb_wen); end
        step();
        vectors++; if (usb_wen !== 1'b0) begin errors++; $display("FAIL single_strobe2: got %b want 0", usb_wen); end
        step();
        vectors++; if (usb_wen !== 1'b1) begin errors++; $display("FAIL single_hold_wen: got %b want 1", usb_wen); end
        vectors++; if (usb_fd_oe !== 1'b1) begin errors++; $display("FAIL single_hold_oe: got %b want 1", usb_fd_oe); end
        vectors++; if (bytes_sent !== 32'd0) begin errors++; $display("FAIL single_hold_sent: got %0d want 0", bytes_sent); end
        step();
        vectors++; if (usb_fd_oe !== 1'b0) begin errors++; $display("FAIL single_idle_oe: got %b want 0", usb_fd_oe); end
        vectors++; if (bytes_sent !== 32'd1) begin errors++; $display("FAIL single_sent: got %0d want 1", bytes_sent); end
        vectors++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL single_level_end: got %0d want 0", fifo_level); end
    endtask

    task automatic test_back_to_back();
        int   sent = 0;
        int   seen = 0;
        int   cyc = 0;
        int   last_cyc = 0;
        logic prev_wen = 1'b1;
        logic acc;
        bit   saw_full = 1'b0;
        tx_valid = 1'b1; tx_data = 8'h00; tx_cmd = 1'b0;
        while (bytes_sent != 32'd21 && cyc < 300) begin
            acc = tx_valid && tx_ready;
            step();
            cyc++;
            if (acc) sent++;
            tx_valid = (sent < 20);
            tx_data  = 8'(sent);
            if (!tx_ready && !saw_full) begin
                saw_full = 1'b1;
                vectors++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL burst_full_level: got %0d want 16", fifo_level); end
            end
            if (prev_wen && !usb_wen) begin
                vectors++; if (usb_fd_out !== 8'(seen)) begin errors++; $display("FAIL burst_order: got %h want %h", usb_fd_out, 8'(seen)); end
                if (seen > 0) begin
                    vectors++; if (cyc - last_cyc != 4) begin errors++; $display("FAIL burst_spacing: got %0d want 4", cyc - last_cyc); end
                end
                last_cyc = cyc;
                seen++;
            end
            prev_wen = usb_wen;
        end
        tx_valid = 1'b0;
        vectors++; if (bytes_sent !== 32'd21) begin errors++; $display("FAIL burst_sent: got %0d want 21", bytes_sent); end
        vectors++; if (seen != 20) begin errors++; $display("FAIL burst_strobes: got %0d want 20", seen); end
        vectors++; if (!saw_full) begin errors++; $display("FAIL burst_ready_drop: got 0 want 1"); end
        vectors++; if (usb_fd_oe !== 1'b0) begin errors++; $display("FAIL burst_oe_end: got %b want 0", usb_fd_oe); end
        vectors++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL burst_level_end: got %0d want 0", fifo_level); end
    endtask

    task automatic test_full_stall();
        usb_full = 1'b1;
        tx_data = 8'h3C; tx_cmd = 1'b0; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 7; i++) begin
            step();
            vectors++; if (usb_wen !== 1'b1 || usb_fd_out !== 8'h3C || usb_fd_oe !== 1'b1) begin
                errors++; $display("FAIL stall_hold[%0d]: got wen=%b fd=%h oe=%b want 1/3c/1", i, usb_wen, usb_fd_out, usb_fd_oe);
            end
        end
        usb_full = 1'b0;
        step();
        vectors++; if (usb_wen !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", usb_wen); end
        usb_full = 1'b1;
        step();
        vectors++; if (usb_wen !== 1'b0) begin errors++; $display("FAIL stall_midstrobe: got %b want 0", usb_wen); end
        step();
        vectors++; if (usb_wen !== 1'b1) begin errors++; $display("FAIL stall_hold_wen: got %b want 1", usb_wen); end
        step();
        vectors++; if (bytes_sent !== 32'd22) begin errors++; $display("FAIL stall_sent: got %0d want 22", bytes_sent); end
        vectors++; if (usb_fd_oe !== 1'b0) begin errors++; $display("FAIL stall_oe_end: got %b want 0", usb_fd_oe); end
        usb_full = 1'b0;
    endtask

    task automatic test_rd_busy();
        int   seen = 0;
        int   cyc = 0;
        logic prev_wen = 1'b1;
        usb_full = 1'b1;
        tx_valid = 1'b1; tx_cmd = 1'b0;
        tx_data = 8'h51; step();
        tx_data = 8'h52; step();
        tx_data = 8'h53; step();
        tx_valid = 1'b0;
        vectors++; if (fifo_level !== 5'd3) begin errors++; $display("FAIL busy_level_pre: got %0d want 3", fifo_level); end
        vectors++; if (usb_fd_oe !== 1'b1) begin errors++; $display("FAIL busy_setup_oe: got %b want 1", usb_fd_oe); end
        usb_rd_busy = 1'b1;
        step();
        vectors++; if (usb_fd_oe !== 1'b0) begin errors++; $display("FAIL busy_release_oe: got %b want 0", usb_fd_oe); end
        vectors++; if (fifo_level !== 5'd3) begin errors++; $display("FAIL busy_level: got %0d want 3", fifo_level); end
        repeat (3) step();
        vectors++; if (usb_fd_oe !== 1'b0 || fifo_level !== 5'd3) begin
            errors++; $display("FAIL busy_wait: got oe=%b level=%0d want 0/3", usb_fd_oe, fifo_level);
        end
        usb_rd_busy = 1'b0; usb_full = 1'b0;
        step();
        vectors++; if (usb_fd_oe !== 1'b1 || usb_fd_out !== 8'h51) begin
            errors++; $display("FAIL busy_turn: got oe=%b fd=%h want 1/51", usb_fd_oe, usb_fd_out);
        end
        while (bytes_sent != 32'd25 && cyc < 60) begin
            step();
            cyc++;
            if (prev_wen && !usb_wen) begin
                vectors++; if (usb_fd_out !== 8'h51 + 8'(seen)) begin
                    errors++; $display("FAIL busy_order: got %h want %h", usb_fd_out, 8'h51 + 8'(seen));
                end
                seen++;
            end
            prev_wen = usb_wen;
        end
        vectors++; if (seen != 3) begin errors++; $display("FAIL busy_strobes: got %0d want 3", seen); end
        vectors++; if (bytes_sent !== 32'd25) begin errors++; $display("FAIL busy_sent: got %0d want 25", bytes_sent); end
        vectors++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL busy_level_end: got %0d want 0", fifo_level); end
    endtask

    task automatic test_reset_mid_strobe();
        int lows = 0;
        usb_full = 1'b0; tx_cmd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tx_data = 8'h60 + 8'(i); tx_valid = 1'b1;
            step();
        end
        tx_valid = 1'b0;
        vectors++; if (usb_wen !== 1'b0) begin errors++; $display("FAIL rst_pre_wen: got %b want 0", usb_wen); end
        vectors++; if (fifo_level !== 5'd5) begin errors++; $display("FAIL rst_pre_level: got %0d want 5", fifo_level); end
        usb_reset = 1'b1;
        step();
        vectors++; if (usb_wen !== 1'b1) begin errors++; $display("FAIL rst_wen: got %b want 1", usb_wen); end
        vectors++; if (usb_fd_oe !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b want 0", usb_fd_oe); end
        vectors++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
        vectors++; if (bytes_sent !== 32'd0) begin errors++; $display("FAIL rst_sent: got %0d want 0", bytes_sent); end
        vectors++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", tx_ready); end
        usb_reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (usb_wen !== 1'b1) lows++;
        end
        vectors++; if (lows != 0) begin errors++; $display("FAIL rst_no_strobe: got %0d low cycles want 0", lows); end
        vectors++; if (bytes_sent !== 32'd0) begin errors++; $display("FAIL rst_sent_after: got %0d want 0", bytes_sent); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_stall();
        test_rd_busy();
        test_reset_mid_strobe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
